write_fifo: RTL and testbench

- Single-clock byte FIFO on the SD-to-USB path, the outbound counterpart of the USB-to-SD read buffer.
- The SD-side block writes bytes as they arrive from the card. The USB bulk-IN transmitter drains them.
- Adds occupancy count, a packet-ready threshold flag and sticky error flags, so the transmitter only starts a bulk packet when a full packet is buffered.

---
 rtl/write_fifo_if.sv | 28 ++
 rtl/write_fifo.sv | 88 ++++++++
 tb/tb_write_fifo.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/write_fifo_if.sv
// Byte-stream bundle between the SD-side writer, the write FIFO and the USB bulk-IN drain.
interface write_fifo_if #(
  parameter int DEPTH = 128
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clear;
  logic              write_enable;
  logic [7:0]        write_data;
  logic              read_enable;
  logic [7:0]        read_data;
  logic              fifo_empty;
  logic              fifo_full;
  logic              packet_ready;
  logic [ADDR_W:0]   byte_count;
  logic              overflow;
  logic              underflow;

  modport master (
    output clear, write_enable, write_data, read_enable,
    input  read_data, fifo_empty, fifo_full, packet_ready, byte_count, overflow, underflow
  );

  modport slave (
    input  clear, write_enable, write_data, read_enable,
    output read_data, fifo_empty, fifo_full, packet_ready, byte_count, overflow, underflow
  );
endinterface

// File: rtl/write_fifo.sv
// Single-clock byte FIFO feeding the USB bulk-IN transmitter, with occupancy count,
// packet-ready threshold and sticky overflow/underflow flags.
module write_fifo #(
  parameter int DEPTH    = 128,
  parameter int PKT_SIZE = 64,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input logic         clk,
  input logic         n_rst,
  write_fifo_if.slave bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] PKT_CNT  = CNT_W'(PKT_SIZE);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        read_data_q, read_data_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_acc, wr_acc;

  // A read frees a slot on the same edge, so a write into a full FIFO is still taken
  // when paired with a read; on an empty FIFO the read is refused (no fall-through).
  always_comb begin
    rd_acc      = bus.read_enable && (count_q != '0);
    wr_acc      = bus.write_enable && ((count_q != FULL_CNT) || rd_acc);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    read_data_d = read_data_q;
    overflow_d  = overflow_q  | (bus.write_enable && !wr_acc);
    underflow_d = underflow_q | (bus.read_enable  && !rd_acc);

    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_acc) begin
      rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
      read_data_d = mem_q[rd_ptr_q];
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is never reset; only the write itself is suppressed under reset or clear.
  always_ff @(posedge clk) begin
    if (n_rst && !bus.clear && wr_acc) mem_q[wr_ptr_q] <= bus.write_data;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      read_data_q <= 8'h00;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      read_data_q <= read_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.read_data    = read_data_q;
  assign bus.byte_count   = count_q;
  assign bus.fifo_empty   = (count_q == '0);
  assign bus.fifo_full    = (count_q == FULL_CNT);
  assign bus.packet_ready = (count_q >= PKT_CNT);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_write_fifo.sv
// Directed bench for write_fifo: read bytes are scored through a queue, state is checked per cycle.
module tb_write_fifo;

  localparam int DEPTH = 128;
  localparam int PKT   = 64;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t       sb[$];
  logic [7:0] mdl[$];
  logic [7:0] m_rd;
  bit         m_ovf, m_unf;
  bit         pr_seen;
  exp_t       mon_e;

  write_fifo_if #(.DEPTH(DEPTH)) bus ();

  write_fifo #(.DEPTH(DEPTH), .PKT_SIZE(PKT)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares read_data against scoreboard entries due this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      total++;
      if (mon_e.cyc != cyc || bus.read_data !== mon_e.val) begin
        bad++;
        $display("FAIL rd_stream: got %02h expected %02h (due cycle %0d, now %0d)",
                 bus.read_data, mon_e.val, mon_e.cyc, cyc);
      end
    end
  end

  task automatic step(input bit we, input logic [7:0] wd, input bit re,
                      input bit clr = 1'b0, input bit rst = 1'b0);
    bit   rd_ok, wr_ok;
    exp_t e;
    n_rst            = ~rst;
    bus.clear        = clr;
    bus.write_enable = we;
    bus.write_data   = wd;
    bus.read_enable  = re;
    if (rst) begin
      mdl.delete(); m_ovf = 0; m_unf = 0; m_rd = 8'h00;
    end else if (clr) begin
      mdl.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      rd_ok = re && (mdl.size() > 0);
      wr_ok = we && ((mdl.size() < DEPTH) || rd_ok);
      if (re && !rd_ok) m_unf = 1;
      if (we && !wr_ok) m_ovf = 1;
      if (rd_ok) begin
        m_rd  = mdl.pop_front();
        e.cyc = cyc + 1;
        e.val = m_rd;
        sb.push_back(e);
      end
      if (wr_ok) mdl.push_back(wd);
    end
    @(posedge clk); #1;
    chk("byte_count", int'(bus.byte_count), mdl.size());
    chk("fifo_empty", int'(bus.fifo_empty), int'(mdl.size() == 0));
    chk("fifo_full", int'(bus.fifo_full), int'(mdl.size() == DEPTH));
    chk("packet_ready", int'(bus.packet_ready), int'(mdl.size() >= PKT));
    chk("overflow", int'(bus.overflow), int'(m_ovf));
    chk("underflow", int'(bus.underflow), int'(m_unf));
    chk("read_data_hold", int'(bus.read_data), int'(m_rd));
    if (bus.packet_ready) pr_seen = 1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] vec [3];
    vec[0] = 8'hA5; vec[1] = 8'h3C; vec[2] = 8'h7E;

    // Reset state
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("rst_empty", int'(bus.fifo_empty), 1);
    chk("rst_count", int'(bus.byte_count), 0);
    chk("rst_rdata", int'(bus.read_data), 0);

    // Three bytes in, three out
    for (int i = 0; i < 3; i++) step(1'b1, vec[i], 1'b0);
    chk("three_count", int'(bus.byte_count), 3);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    chk("third_byte", int'(bus.read_data), 8'h7E);
    chk("three_empty", int'(bus.fifo_empty), 1);

    // Fill to full, threshold, overflow, drain
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i == PKT - 2) chk("pr_below", int'(bus.packet_ready), 0);
      if (i == PKT - 1) chk("pr_at_64", int'(bus.packet_ready), 1);
    end
    chk("full_count", int'(bus.byte_count), 128);
    chk("full_flag", int'(bus.fifo_full), 1);
    step(1'b1, 8'hFF, 1'b0);
    chk("ovf_set", int'(bus.overflow), 1);
    chk("ovf_count", int'(bus.byte_count), 128);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain_last", int'(bus.read_data), 127);

    // Simultaneous read/write while full
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'hEE, 1'b1);
    chk("rw_full_count", int'(bus.byte_count), 128);
    chk("rw_full_flag", int'(bus.fifo_full), 1);
    chk("rw_first10", int'(bus.read_data), 9);
    for (int i = 0; i < 118; i++) step(1'b0, 8'h00, 1'b1);
    chk("rw_orig_tail", int'(bus.read_data), 127);
    step(1'b0, 8'h00, 1'b1);
    chk("rw_ee_first", int'(bus.read_data), 8'hEE);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1);

    // Read and write on empty
    idle();
    step(1'b1, 8'h55, 1'b1);
    chk("ue_underflow", int'(bus.underflow), 1);
    chk("ue_count", int'(bus.byte_count), 1);
    chk("ue_rdata_hold", int'(bus.read_data), 8'hEE);
    step(1'b0, 8'h00, 1'b1);
    chk("ue_next_read", int'(bus.read_data), 8'h55);

    // Streaming at occupancy 40 across pointer wrap
    step(1'b0, 8'h00, 1'b0, 1'b1);
    pr_seen = 0;
    for (int i = 0; i < 40; i++) step(1'b1, 8'(i * 7 + 3), 1'b0);
    for (int i = 40; i < 200; i++) step(1'b1, 8'(i * 7 + 3), 1'b1);
    chk("stream_count", int'(bus.byte_count), 40);
    for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 1'b1);
    chk("stream_pr_never", int'(pr_seen), 0);
    chk("stream_last", int'(bus.read_data), int'(8'(199 * 7 + 3)));

    // Clear with count=50 and overflow set
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 8'(i + 16), 1'b0);
    for (int i = 0; i < DEPTH - 50; i++) step(1'b0, 8'h00, 1'b1);
    chk("pre_clr_count", int'(bus.byte_count), 50);
    chk("pre_clr_ovf", int'(bus.overflow), 1);
    step(1'b1, 8'h99, 1'b0, 1'b1);
    chk("clr_count", int'(bus.byte_count), 0);
    chk("clr_empty", int'(bus.fifo_empty), 1);
    chk("clr_ovf", int'(bus.overflow), 0);
    chk("clr_rdata_hold", int'(bus.read_data), int'(8'(DEPTH - 50 - 1 + 16)));
    idle();

    // Reset mid-stream
    for (int i = 0; i < 52; i++) step(1'b1, 8'(i + 200), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("pre_rst_rdata", int'(bus.read_data), 201);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    chk("rst_mid_count", int'(bus.byte_count), 0);
    chk("rst_mid_empty", int'(bus.fifo_empty), 1);
    chk("rst_mid_rdata", int'(bus.read_data), 0);
    idle();
    step(1'b1, 8'h42, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("post_rst_read", int'(bus.read_data), 8'h42);
    idle();

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL sb_drain: %0d entries left expected 0", sb.size());
    end
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
